// File: rtl/ex_div.sv
`timescale 1ns/1ps
// Iterative radix-2 restoring divider for DIV/DIVU in the execute stage.
// Latency: WIDTH cycles accept-to-ready (1 cycle for a zero divisor).
// Backpressure: start_i is held until ready_o; the result is held in END while
// start_i stays high, and stallreq_o freezes the pipeline while a divide is pending.
// Ports: clk/rst (async active-low), signed_div_i, opdata1_i (dividend), opdata2_i
// (divisor), start_i, annul_i in; result_o {rem,quo}, ready_o, stallreq_o out.
module ex_div #(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 signed_div_i,
    input  logic [WIDTH-1:0]     opdata1_i,
    input  logic [WIDTH-1:0]     opdata2_i,
    input  logic                 start_i,
    input  logic                 annul_i,
    output logic [2*WIDTH-1:0]   result_o,
    output logic                 ready_o,
    output logic                 stallreq_o
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {S_FREE, S_BYZERO, S_ON, S_END} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_rem;    // partial remainder
    logic [WIDTH-1:0] r_dvd;    // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] r_dvs;    // divisor magnitude
    logic             r_neg_q;
    logic             r_neg_r;

    // Operand magnitudes; for the most negative value the negation wraps to
    // itself, which read as unsigned is the correct magnitude 2^(WIDTH-1).
    logic             w_neg1;
    logic             w_neg2;
    logic [WIDTH-1:0] w_abs1;
    logic [WIDTH-1:0] w_abs2;
    logic             w_accept;

    assign w_neg1   = signed_div_i & opdata1_i[WIDTH-1];
    assign w_neg2   = signed_div_i & opdata2_i[WIDTH-1];
    assign w_abs1   = w_neg1 ? (~opdata1_i + 1'b1) : opdata1_i;
    assign w_abs2   = w_neg2 ? (~opdata2_i + 1'b1) : opdata2_i;
    assign w_accept = start_i & ~annul_i;

    // One restoring step: shift, trial-subtract, keep the difference when the
    // subtract does not borrow (the extra top bit catches the borrow).
    logic [WIDTH:0]   w_prem;
    logic [WIDTH+1:0] w_sub;
    logic             w_ge;
    logic [WIDTH-1:0] w_rem_nx;
    logic [WIDTH-1:0] w_quo_nx;
    logic [WIDTH-1:0] w_rem_fix;
    logic [WIDTH-1:0] w_quo_fix;
    logic             w_last;

    assign w_prem    = {r_rem, r_dvd[WIDTH-1]};
    assign w_sub     = {1'b0, w_prem} - {2'b00, r_dvs};
    assign w_ge      = ~w_sub[WIDTH+1];
    assign w_rem_nx  = w_ge ? w_sub[WIDTH-1:0] : w_prem[WIDTH-1:0];
    assign w_quo_nx  = {r_dvd[WIDTH-2:0], w_ge};
    assign w_rem_fix = r_neg_r ? (~w_rem_nx + 1'b1) : w_rem_nx;
    assign w_quo_fix = r_neg_q ? (~w_quo_nx + 1'b1) : w_quo_nx;
    assign w_last    = (r_cnt == CW'(WIDTH - 1));

    assign stallreq_o = start_i & ~ready_o & ~annul_i;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_FREE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_FREE: begin
                if (w_accept) begin
                    w_next = (opdata2_i == '0) ? S_BYZERO : S_ON;
                end
            end
            S_BYZERO: w_next = annul_i ? S_FREE : S_END;
            S_ON: begin
                if (annul_i) begin
                    w_next = S_FREE;
                end else if (w_last) begin
                    w_next = S_END;
                end
            end
            S_END: begin
                if (annul_i || !start_i) begin
                    w_next = S_FREE;
                end
            end
            default: w_next = S_FREE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt    <= '0;
            r_rem    <= '0;
            r_dvd    <= '0;
            r_dvs    <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            result_o <= '0;
            ready_o  <= 1'b0;
        end else begin
            case (r_state)
                S_FREE: begin
                    if (w_accept && (opdata2_i != '0)) begin
                        r_cnt   <= '0;
                        r_rem   <= '0;
                        r_dvd   <= w_abs1;
                        r_dvs   <= w_abs2;
                        r_neg_q <= w_neg1 ^ w_neg2;
                        r_neg_r <= w_neg1;
                    end
                end
                S_BYZERO: begin
                    if (!annul_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b1;
                    end
                end
                S_ON: begin
                    if (annul_i) begin
                        r_cnt    <= '0;
                        r_rem    <= '0;
                        r_dvd    <= '0;
                        r_dvs    <= '0;
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end else begin
                        r_rem <= w_rem_nx;
                        r_dvd <= w_quo_nx;
                        r_cnt <= r_cnt + CW'(1);
                        if (w_last) begin
                            result_o <= {w_rem_fix, w_quo_fix};
                            ready_o  <= 1'b1;
                        end
                    end
                end
                S_END: begin
                    if (annul_i || !start_i) begin
                        result_o <= '0;
                        ready_o  <= 1'b0;
                    end
                end
                default: begin
                    result_o <= '0;
                    ready_o  <= 1'b0;
                end
            endcase
        end
    end
endmodule
